// File: rtl/lifo_stack.sv
// lifo_stack: parameterised LIFO with registered read data.
// Flags decode straight from the occupancy counter. Storage words are never
// cleared; only the counter and the read register are reset.
module lifo_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int LIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  read_lifo_i,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int CW = $clog2(LIFO_DEPTH) + 1;
    localparam int AW = $clog2(LIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [LIFO_DEPTH];
    logic [CW-1:0]         count;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         wr_idx;
    logic                  do_swap;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_peek;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(LIFO_DEPTH));

    // Top entry sits at count-1; only used when the stack is non-empty.
    assign top_idx = AW'(count - CW'(1));

    // Push+pop on a non-empty stack replaces the top in place. With an empty
    // stack the pop half is meaningless, so it degrades to a plain push.
    assign do_swap = push_i && pop_i && !empty_o;
    assign do_pop  = pop_i && !push_i && !empty_o;
    assign do_push = push_i && (!pop_i || empty_o) && !full_o;
    assign do_peek = read_lifo_i && !push_i && !pop_i && !empty_o;

    // A plain push writes the slot just above the top; a swap reuses the top.
    assign wr_idx = do_swap ? top_idx : count[AW-1:0];

    // Storage array: written on push or swap, never reset.
    always_ff @(posedge clk) begin
        if (do_swap || do_push) begin
            mem[wr_idx] <= data_i;
        end
    end

    // Occupancy counter and read register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            data_o <= '0;
        end else begin
            if (do_swap || do_pop || do_peek) begin
                data_o <= mem[top_idx];
            end
            if (do_pop) begin
                count <= count - CW'(1);
            end else if (do_push) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios plus randomized traffic, checked against
// a queue-based reference stack.
module tb_lifo_stack;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_i;
    logic          push_i;
    logic          pop_i;
    logic          read_lifo_i;
    logic          empty_o;
    logic          full_o;
    logic [DW-1:0] data_o;

    int checks;
    int errors;

    // Reference model: a queue whose back is the top of stack.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_data;

    lifo_stack #(.DATA_WIDTH(DW), .LIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data_i),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .read_lifo_i(read_lifo_i),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .data_o     (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of requests across one rising edge, update the model,
    // then return to idle 1 time unit after the edge.
    task automatic drive_cycle(input logic push, input logic pop, input logic rd,
                               input logic [DW-1:0] d);
        push_i      = push;
        pop_i       = pop;
        read_lifo_i = rd;
        data_i      = d;
        @(posedge clk);
        #1;
        if (push && pop && m_q.size() > 0) begin
            m_data = m_q[$];
            m_q[$] = d;
        end else if (pop && !push && m_q.size() > 0) begin
            m_data = m_q.pop_back();
        end else if (push && m_q.size() < DEPTH) begin
            m_q.push_back(d);
        end else if (rd && !push && !pop && m_q.size() > 0) begin
            m_data = m_q[$];
        end
        push_i      = 1'b0;
        pop_i       = 1'b0;
        read_lifo_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        m_q.delete();
        m_data = '0;
        @(posedge clk);
        #1;
        checks++;
        if (empty_o !== 1'b1) begin
            errors++; $display("FAIL reset_empty: empty_o=%0b expected 1", empty_o);
        end
        checks++;
        if (full_o !== 1'b0) begin
            errors++; $display("FAIL reset_full: full_o=%0b expected 0", full_o);
        end
        checks++;
        if (data_o !== '0) begin
            errors++; $display("FAIL reset_data: data_o=%h expected 0", data_o);
        end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, vals[i]);
            checks++;
            if (empty_o !== 1'b0) begin
                errors++; $display("FAIL fill_empty[%0d]: empty_o=%0b expected 0", i, empty_o);
            end
            checks++;
            if (full_o !== (i == 3)) begin
                errors++; $display("FAIL fill_full[%0d]: full_o=%0b expected %0b", i, full_o, (i == 3));
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h55);
        checks++;
        if (full_o !== 1'b1) begin
            errors++; $display("FAIL overflow_full: full_o=%0b expected 1", full_o);
        end
        checks++;
        if (data_o !== m_data) begin
            errors++; $display("FAIL overflow_data: data_o=%h expected %h", data_o, m_data);
        end
    endtask

    task automatic test_drain_underflow();
        logic [DW-1:0] exp [4] = '{32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (data_o !== exp[i]) begin
                errors++; $display("FAIL drain_data[%0d]: data_o=%h expected %h", i, data_o, exp[i]);
            end
            checks++;
            if (empty_o !== (i == 3)) begin
                errors++; $display("FAIL drain_empty[%0d]: empty_o=%0b expected %0b", i, empty_o, (i == 3));
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== 32'h11) begin
            errors++; $display("FAIL underflow_data: data_o=%h expected 11", data_o);
        end
        checks++;
        if (empty_o !== 1'b1) begin
            errors++; $display("FAIL underflow_empty: empty_o=%0b expected 1", empty_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (data_o !== 32'h11) begin
            errors++; $display("FAIL underflow_peek: data_o=%h expected 11", data_o);
        end
    endtask

    task automatic test_peek();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hA5);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (data_o !== 32'hA5) begin
                errors++; $display("FAIL peek_data[%0d]: data_o=%h expected a5", i, data_o);
            end
            checks++;
            if (empty_o !== 1'b0 || full_o !== 1'b0) begin
                errors++; $display("FAIL peek_flags[%0d]: empty_o=%0b full_o=%0b expected 0 0", i, empty_o, full_o);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== 32'hA5 || empty_o !== 1'b1) begin
            errors++; $display("FAIL peek_pop: data_o=%h empty_o=%0b expected a5 1", data_o, empty_o);
        end
    endtask

    task automatic test_push_pop();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h01);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h02);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h03);
        checks++;
        if (data_o !== 32'h02) begin
            errors++; $display("FAIL swap_data: data_o=%h expected 02", data_o);
        end
        checks++;
        if (empty_o !== 1'b0 || full_o !== 1'b0 || m_q.size() != 2) begin
            errors++; $display("FAIL swap_flags: empty_o=%0b full_o=%0b expected 0 0", empty_o, full_o);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== 32'h03) begin
            errors++; $display("FAIL swap_next_pop: data_o=%h expected 03", data_o);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== 32'h01 || empty_o !== 1'b1) begin
            errors++; $display("FAIL swap_last_pop: data_o=%h empty_o=%0b expected 01 1", data_o, empty_o);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h07);
        checks++;
        if (data_o !== 32'h01 || empty_o !== 1'b0) begin
            errors++; $display("FAIL swap_empty: data_o=%h empty_o=%0b expected 01 0", data_o, empty_o);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== 32'h07 || empty_o !== 1'b1) begin
            errors++; $display("FAIL swap_empty_pop: data_o=%h empty_o=%0b expected 07 1", data_o, empty_o);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC1);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC2);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC3);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC4);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0) begin
            errors++; $display("FAIL async_flags: empty_o=%0b full_o=%0b expected 1 0", empty_o, full_o);
        end
        checks++;
        if (data_o !== '0) begin
            errors++; $display("FAIL async_data: data_o=%h expected 0", data_o);
        end
        reset = 1'b1;
        m_q.delete();
        m_data = '0;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (data_o !== '0 || empty_o !== 1'b1) begin
            errors++; $display("FAIL async_after_pop: data_o=%h empty_o=%0b expected 0 1", data_o, empty_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom());
            checks++;
            if (data_o !== m_data || empty_o !== (m_q.size() == 0) ||
                full_o !== (m_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random[%0d]: data_o=%h empty_o=%0b full_o=%0b expected %h %0b %0b",
                         i, data_o, empty_o, full_o, m_data, (m_q.size() == 0), (m_q.size() == DEPTH));
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        push_i      = 1'b0;
        pop_i       = 1'b0;
        read_lifo_i = 1'b0;
        data_i      = '0;
        m_data      = '0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_peek();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parameterised synchronous LIFO (stack) buffer with registered read data and combinational full/empty flags.
- Serves as a generic storage primitive in the common RTL library, for example as a return-address or context stack inside the core.
- Supports push, destructive pop, non-destructive top-of-stack read (peek), and simultaneous push+pop.

Parameters:
- DATA_WIDTH, 32, width of each stored word in bits.
- LIFO_DEPTH, 4, number of entries. Must be >= 2. Need not be a power of two.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it low clears state immediately; deassertion is synchronised externally.
- data_i  input  DATA_WIDTH  word to push.
- push_i  input  1  push request, sampled on rising clk.
- pop_i  input  1  pop request, sampled on rising clk.
- read_lifo_i  input  1  peek request: copy top entry to data_o without removing it.
- empty_o  output  1  high when the stack holds 0 entries.
- full_o  output  1  high when the stack holds LIFO_DEPTH entries.
- data_o  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array of LIFO_DEPTH words plus an occupancy counter `count`, width $clog2(LIFO_DEPTH)+1, range 0..LIFO_DEPTH. The top entry is index count-1.
- Reset (reset low, asynchronous):
  - count=0, data_o=0, so empty_o=1 and full_o=0.
  - Memory contents are not cleared and are don't-care.
  - Reset mid-operation discards all entries immediately.
- Flags are combinational from count: empty_o = (count==0), full_o = (count==LIFO_DEPTH). They reflect the new count the cycle after the update edge.
- Single-edge operation priority, evaluated each rising edge with reset high:
  1. push_i=1, pop_i=1, not empty:
     - data_o <= current top.
     - Top slot overwritten with data_i.
     - count unchanged.
  2. push_i=1, pop_i=1, empty:
     - Pop is ignored; the push proceeds per rule 4.
     - data_o holds.
  3. pop_i=1 only, not empty: data_o <= mem[count-1]; count <= count-1.
  4. push_i=1 only, not full: mem[count] <= data_i; count <= count+1. data_o holds.
  5. read_lifo_i=1 (no push/pop), not empty: data_o <= mem[count-1]; count unchanged.
  6. Otherwise data_o and count hold.
- read_lifo_i is ignored whenever push_i or pop_i is asserted.
- Pop latency: data is valid on data_o one clock after the edge that samples pop_i. Same for read_lifo_i.
- Overflow: push when full (without pop) is dropped. count and contents are unchanged and data_o holds. No error flag.
- Underflow: pop or peek when empty is ignored. count stays 0 and data_o holds its previous value.
- No wrap-around: the counter saturates at 0 and LIFO_DEPTH by the rules above.
- All outputs are defined (no X) after reset. data_o never changes except on a successful pop, peek, or push+pop.

Test Plan:
- Reset: hold reset low 3 cycles, release, wait 1 edge -> empty_o=1, full_o=0, data_o=0.
- Fill and overflow:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive edges -> empty_o=0 after the first push; full_o=1 after the fourth.
  - Push 0x55 -> full_o stays 1 and contents are unchanged.
- Drain order and underflow:
  - Pop 4 times -> data_o = 0x44, 0x33, 0x22, 0x11, each one cycle after its pop; empty_o=1 after the last.
  - Extra pop -> data_o stays 0x11, empty_o stays 1.
- Peek: push 0xA5, assert read_lifo_i twice -> data_o=0xA5 both times; count stays 1 (empty_o=0, full_o=0). A following pop returns 0xA5, then empty_o=1.
- Simultaneous push+pop:
  - Stack holding 0x01, 0x02 (top), push 0x03 with pop -> data_o=0x02, count stays 2; next pop -> 0x03.
  - On an empty stack, push+pop of 0x07 -> count=1, data_o unchanged.
- Async reset mid-operation: with 3 entries, drive reset low between clock edges -> empty_o=1, full_o=0, data_o=0 immediately, without waiting for a clk edge.
